mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIE_DATA_FIRST, default 1; 1 = data port wins the first simultaneous request after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port if_req, input, 1: fetch request; held until if_gnt.
REQ-005 SHALL have port if_addr, input, addr_t: fetch byte address.
REQ-006 SHALL have port if_gnt, output, 1: one-cycle pulse; fetch request accepted.
REQ-007 SHALL have port if_rvalid, output, 1: one-cycle pulse; if_rdata valid.
REQ-008 SHALL have port if_rdata, output, data_t: fetched word.
REQ-009 SHALL have port d_req, input, 1: data request; held until d_gnt.
REQ-010 SHALL have port d_addr, input, addr_t: data byte address.
REQ-011 SHALL have port d_wdata, input, data_t: store data.
REQ-012 SHALL have port d_wstrb, input, 4: byte-lane write strobes; 4'b0000 = load.
REQ-013 SHALL have port d_gnt, output, 1: one-cycle pulse; data request accepted.
REQ-014 SHALL have port d_rvalid, output, 1: one-cycle pulse; load data valid or store complete.
REQ-015 SHALL have port d_rdata, output, data_t: loaded word; unchanged on stores.
REQ-016 SHALL have port mem_address, output, addr_t: to memory-map address.
REQ-017 SHALL have port mem_write_data, output, data_t: to memory-map write data.
REQ-018 SHALL have port mem_write_enable, output, 4: to memory-map byte write enables.
REQ-019 SHALL have port mem_read_data, input, data_t: from memory-map; registered for RAM, combinational for MMIO, both valid one cycle after the address is presented.
REQ-020 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-022 IDLE: if any req is high, SHALL select one winner, pulse its gnt, latch addr/wdata/wstrb (fetch: wstrb=0), and go to ISSUE; else stay.
REQ-023 Arbitration SHALL be round-robin: on tie, grant the port not granted last; a lone requester is always granted; last-grant updates on every grant.
REQ-024 ISSUE: SHALL drive mem_address/mem_write_data from latches; mem_write_enable = latched wstrb in this cycle only.
REQ-025 ISSUE with nonzero wstrb SHALL pulse d_rvalid next cycle and return to IDLE (store latency: gnt at N, write at N+1, ack at N+2).
REQ-026 ISSUE with zero wstrb SHALL go to RESP with mem_write_enable = 0.
REQ-027 RESP: SHALL keep mem_address held, capture mem_read_data into the winner's rdata register at cycle end, pulse that port's rvalid next cycle, return to IDLE (load latency: gnt N, rvalid N+3).
REQ-028 A new grant MAY occur in IDLE in the same cycle an rvalid pulse is asserted.
REQ-029 In IDLE and RESP, mem_write_enable SHALL be 4'b0000; mem_address SHALL hold its last value.
REQ-030 Addresses SHALL pass unmodified (no alignment check; memory ignores low bits).
REQ-031 The non-winning port's gnt/rvalid/rdata SHALL be unaffected by the other port's transaction.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, all gnt/rvalid low, mem_write_enable 4'b0000, busy 0, mem_address 0, mem_write_data 0, if_rdata/d_rdata 0, last-grant per TIE_DATA_FIRST.
REQ-033 Reset mid-transaction SHALL drop the transaction with no rvalid and no write issued after assertion.

Structure
REQ-034 addr_t and data_t SHALL come from the shared types header; FSM state enum SHALL be local to the module.
REQ-035 No sub-module SHALL be used; the 2-way round-robin pick is inline logic.

Verification
REQ-036 Fetch only: if_req, if_addr=0x8 with memory word 0x00A00093 -> if_gnt at N, if_rvalid at N+3, if_rdata=0x00A00093.
REQ-037 Store: d_addr=0x10000000, d_wdata=0x3FF, d_wstrb=4'hF -> mem_write_enable=4'hF one cycle at N+1, d_rvalid at N+2, LEDR=0x3FF.
REQ-038 Simultaneous if_req and d_req held after reset -> d_gnt first, if_gnt next, alternating thereafter; no starvation over 10 grants.
REQ-039 Byte store d_addr=0x4, d_wstrb=4'b0100, d_wdata=0x00AB0000 over word 0x11223344, then load 0x4 -> d_rdata=0x11AB3344.
REQ-040 reset_n low during RESP of a fetch -> no if_rvalid, busy=0 immediately, next request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Address, data and byte-strobe widths used across the core's memory path.
package mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    localparam strb_t STRB_NONE = 4'b0000;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory map.
// One transaction in flight: IDLE grants, ISSUE drives memory, RESP returns load data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIE_DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  addr_t       if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output data_t       if_rdata,
    input  logic        d_req,
    input  addr_t       d_addr,
    input  data_t       d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output data_t       d_rdata,
    output addr_t       mem_address,
    output data_t       mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  data_t       mem_read_data,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0] state;
    logic       last_d;
    logic       own_d;
    strb_t      wstrb_q;
    logic       grant;
    logic       pick_d;

    // On a tie the data port wins unless it was the last one served.
    always_comb begin
        grant  = (state == S_IDLE) && reset_n && (if_req || d_req);
        pick_d = d_req && (!if_req || !last_d);
    end

    assign if_gnt           = grant && !pick_d;
    assign d_gnt            = grant && pick_d;
    assign busy             = (state != S_IDLE);
    assign mem_write_enable = (state == S_ISSUE) ? wstrb_q : STRB_NONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            last_d         <= (TIE_DATA_FIRST == 0);
            own_d          <= 1'b0;
            wstrb_q        <= STRB_NONE;
            mem_address    <= '0;
            mem_write_data <= '0;
            if_rdata       <= '0;
            d_rdata        <= '0;
            if_rvalid      <= 1'b0;
            d_rvalid       <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state       <= S_ISSUE;
                        last_d      <= pick_d;
                        own_d       <= pick_d;
                        mem_address <= pick_d ? d_addr : if_addr;
                        wstrb_q     <= pick_d ? d_wstrb : STRB_NONE;
                        if (pick_d) begin
                            mem_write_data <= d_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (wstrb_q != STRB_NONE) begin
                        d_rvalid <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (own_d) begin
                        d_rdata  <= mem_read_data;
                        d_rvalid <= 1'b1;
                    end else begin
                        if_rdata  <= mem_read_data;
                        if_rvalid <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory-map model, transaction-level
// reference (shadow memory, grant order, latencies) and directed plus random traffic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    addr_t       if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    data_t       if_rdata;
    logic        d_req;
    addr_t       d_addr;
    data_t       d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    data_t       d_rdata;
    addr_t       mem_address;
    data_t       mem_write_data;
    logic [3:0]  mem_write_enable;
    data_t       mem_read_data;
    logic        busy;

    mem_arbiter #(.TIE_DATA_FIRST(1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_wstrb(d_wstrb),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data),
        .busy(busy)
    );

    localparam addr_t LEDR = 32'h1000_0000;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    data_t ram [0:64];
    data_t shadow [0:64];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx(input addr_t a);
        if (a == LEDR) return 64;
        return int'(a[7:2]);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory map: read data one cycle after the address, byte-lane writes.
    always @(posedge clk) begin
        mem_read_data <= ram[idx(mem_address)];
        for (int b = 0; b < 4; b++) begin
            if (mem_write_enable[b])
                ram[idx(mem_address)][8*b +: 8] = mem_write_data[8*b +: 8];
        end
    end

    // Reference model state
    int    free_cyc = 0;
    int    issue_cyc = -1;
    int    if_due = -1;
    int    d_due = -1;
    int    we_cyc = -1;
    logic  [3:0] we_exp;
    addr_t addr_exp;
    data_t wd_exp;
    data_t if_hold, d_hold, if_next, d_next;
    logic  last_was_d;
    logic  idle, win, eg_i, eg_d;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_busy", busy, 0);
            check("rst_if_gnt", if_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_if_rvalid", if_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            check("rst_mem_we", mem_write_enable, 0);
            check("rst_mem_addr", mem_address, 0);
            check("rst_mem_wdata", mem_write_data, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            free_cyc = 0;
            issue_cyc = -1;
            if_due = -1;
            d_due = -1;
            we_cyc = -1;
            last_was_d = 1'b0;
            if_hold = '0;
            d_hold = '0;
        end else begin
            idle = (cyc >= free_cyc);
            check("busy", busy, !idle);
            eg_i = 1'b0;
            eg_d = 1'b0;
            if (idle && (if_req || d_req)) begin
                if (if_req && d_req) win = !last_was_d;
                else win = d_req;
                eg_d = win;
                eg_i = !win;
            end
            check("if_gnt", if_gnt, eg_i);
            check("d_gnt", d_gnt, eg_d);
            if (cyc == if_due) if_hold = if_next;
            if (cyc == d_due) d_hold = d_next;
            check("if_rvalid", if_rvalid, cyc == if_due);
            check("d_rvalid", d_rvalid, cyc == d_due);
            check("if_rdata", if_rdata, if_hold);
            check("d_rdata", d_rdata, d_hold);
            check("mem_we", mem_write_enable, (cyc == we_cyc) ? we_exp : 4'h0);
            if (cyc >= issue_cyc && cyc < free_cyc)
                check("mem_addr", mem_address, addr_exp);
            if (cyc == we_cyc)
                check("mem_wdata", mem_write_data, wd_exp);
            if (eg_i || eg_d) begin
                last_was_d = eg_d;
                issue_cyc = cyc + 1;
                if (eg_i) begin
                    addr_exp = if_addr;
                    if_next = shadow[idx(if_addr)];
                    if_due = cyc + 3;
                    free_cyc = cyc + 3;
                end else begin
                    addr_exp = d_addr;
                    if (d_wstrb != 4'h0) begin
                        for (int b = 0; b < 4; b++) begin
                            if (d_wstrb[b])
                                shadow[idx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                        we_cyc = cyc + 1;
                        we_exp = d_wstrb;
                        wd_exp = d_wdata;
                        d_next = d_hold;
                        d_due = cyc + 2;
                        free_cyc = cyc + 2;
                    end else begin
                        d_next = shadow[idx(d_addr)];
                        d_due = cyc + 3;
                        free_cyc = cyc + 3;
                    end
                end
            end
        end
    end

    task automatic fetch(input addr_t a, output data_t rd);
        bit ok;
        rd = '0;
        @(posedge clk) #1;
        if_req = 1'b1;
        if_addr = a;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_gnt) begin ok = 1'b1; break; end
        end
        if (!ok) check("if_gnt_timeout", 0, 1);
        @(posedge clk) #1;
        if_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_rvalid) begin ok = 1'b1; rd = if_rdata; break; end
        end
        if (!ok) check("if_rvalid_timeout", 0, 1);
    endtask

    task automatic data_op(input addr_t a, input data_t wd,
                           input logic [3:0] st, output data_t rd);
        bit ok;
        rd = '0;
        @(posedge clk) #1;
        d_req = 1'b1;
        d_addr = a;
        d_wdata = wd;
        d_wstrb = st;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_gnt) begin ok = 1'b1; break; end
        end
        if (!ok) check("d_gnt_timeout", 0, 1);
        @(posedge clk) #1;
        d_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_rvalid) begin ok = 1'b1; rd = d_rdata; break; end
        end
        if (!ok) check("d_rvalid_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    data_t rd, rd_f, rd_d;
    int    n;
    data_t v;

    initial begin
        reset_n = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        d_wstrb = 4'h0;
        for (int i = 0; i < 65; i++) begin
            v = (i * 32'h0101_0101) ^ 32'h5A5A_5A5A;
            ram[i] = v;
            shadow[i] = v;
        end
        ram[1] = 32'h1122_3344;
        shadow[1] = 32'h1122_3344;
        ram[2] = 32'h00A0_0093;
        shadow[2] = 32'h00A0_0093;
        ram[64] = '0;
        shadow[64] = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Both ports held: data first, then strict alternation.
        @(posedge clk) #1;
        if_req = 1'b1;
        if_addr = 32'h24;
        d_req = 1'b1;
        d_addr = 32'h20;
        d_wstrb = 4'h0;
        n = 0;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                check("rr_order_d", d_gnt, (n % 2) == 0);
                n++;
            end
        end
        check("rr_grants", n, 10);
        @(posedge clk) #1;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (5) @(posedge clk);

        fetch(32'h8, rd);
        check("fetch_word", rd, 32'h00A0_0093);

        data_op(LEDR, 32'h3FF, 4'hF, rd);
        check("ledr", ram[64], 32'h3FF);

        data_op(32'h4, 32'h00AB_0000, 4'b0100, rd);
        data_op(32'h4, 32'h0, 4'h0, rd);
        check("byte_merge", rd, 32'h11AB_3344);

        // Reset during the RESP cycle of a fetch.
        @(posedge clk) #1;
        if_req = 1'b1;
        if_addr = 32'h8;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_gnt) begin n = 1; break; end
        end
        check("rst_fetch_gnt", n, 1);
        @(posedge clk) #1;
        if_req = 1'b0;
        @(posedge clk) #1;
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_busy_now", busy, 0);
        check("rst_we_now", mem_write_enable, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", if_rvalid, 0);
        end
        @(posedge clk) #1;
        reset_n = 1'b1;
        fetch(32'h8, rd);
        check("post_rst_fetch", rd, 32'h00A0_0093);

        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    fetch(addr_t'($urandom_range(0, 255)), rd_f);
                end
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    data_op(addr_t'($urandom_range(0, 255)), $urandom,
                            $urandom_range(0, 1) ? 4'h0
                                                 : 4'($urandom_range(1, 15)),
                            rd_d);
                end
            end
        join
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
